// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the three-port SRAM arbiter.
package sram_arb_pkg;

  localparam int NPORTS = 3;

  typedef logic [1:0] port_t;

  localparam port_t PORT_VGA = 2'd0;
  localparam port_t PORT_M1  = 2'd1;
  localparam port_t PORT_M2  = 2'd2;

  typedef enum logic {
    S_ARB_IDLE,
    S_ARB_BUSY
  } arb_state_e;

  typedef struct packed {
    logic  valid;
    port_t port;
  } rtag_t;

  function automatic port_t next_port(port_t p);
    return (p == PORT_M2) ? PORT_VGA : p + 2'd1;
  endfunction

  function automatic logic [NPORTS-1:0] port_oh(port_t p);
    return NPORTS'(1) << p;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side and SRAM-side bus of the arbiter.
interface sram_arbiter_if;
  import sram_arb_pkg::*;

  logic [NPORTS-1:0]       req_i;
  logic [NPORTS-1:0]       lock_i;
  logic [NPORTS-1:0]       we_n_i;
  logic [NPORTS-1:0][17:0] addr_i;
  logic [NPORTS-1:0][15:0] wdata_i;
  logic [NPORTS-1:0]       gnt_o;
  logic [15:0]             rdata_o;
  logic [NPORTS-1:0]       rvalid_o;
  logic [17:0]             SRAM_address;
  logic [15:0]             SRAM_write_data;
  logic                    SRAM_we_n;
  logic [15:0]             SRAM_read_data;

  modport master (
    output req_i, lock_i, we_n_i,
    output addr_i, wdata_i,
    output SRAM_read_data,
    input  gnt_o, rdata_o, rvalid_o,
    input  SRAM_address, SRAM_write_data,
    input  SRAM_we_n
  );

  modport slave (
    input  req_i, lock_i, we_n_i,
    input  addr_i, wdata_i,
    input  SRAM_read_data,
    output gnt_o, rdata_o, rvalid_o,
    output SRAM_address, SRAM_write_data,
    output SRAM_we_n
  );

endinterface

// File: rtl/sram_arb_pick.sv
// One-hot picker: first requester found searching upward from i_start.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic [NPORTS-1:0] i_req,
  input  port_t             i_start,
  output logic [NPORTS-1:0] o_gnt
);

  logic  w_found;
  port_t w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = i_start;
    for (int i = 0; i < NPORTS; i++) begin
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
      w_idx = next_port(w_idx);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Three-port SRAM arbiter with burst locking and tagged read return.
// Define SRAM_ARB_RR_EN for round-robin idle arbitration (else fixed priority).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_BURST    = 16,
  parameter int READ_LATENCY = 2
)(
  input logic           Clock,
  input logic           Resetn,
  sram_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e        r_state, w_state_nxt;
  port_t             r_owner, w_owner_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [NPORTS-1:0] r_excl, w_excl_nxt;
  logic [NPORTS-1:0] w_avail, w_mask;
  logic [NPORTS-1:0] w_pick, w_gnt;
  port_t             w_start, w_pidx, w_gidx;
  logic              w_exit;
  logic [17:0]       r_addr;
  logic [15:0]       r_wdata;
  logic              r_we_n;
  rtag_t             r_tag [READ_LATENCY+1];

`ifdef SRAM_ARB_RR_EN
  port_t r_ptr, w_ptr_nxt;
  assign w_start = r_ptr;
`else
  assign w_start = PORT_VGA;
`endif

  // A just-released burst owner steps aside for one cycle if others wait.
  assign w_avail = bus.req_i & ~r_excl;
  assign w_mask  = (|w_avail) ? w_avail : bus.req_i;

  sram_arb_pick u_pick (
    .i_req   (w_mask),
    .i_start (w_start),
    .o_gnt   (w_pick)
  );

  always_comb begin
    w_pidx = PORT_VGA;
    unique case (1'b1)
      w_pick[PORT_M1]: w_pidx = PORT_M1;
      w_pick[PORT_M2]: w_pidx = PORT_M2;
      default:         w_pidx = PORT_VGA;
    endcase
  end

  assign w_gidx = (r_state == S_ARB_BUSY) ? r_owner : w_pidx;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_excl_nxt  = '0;
    w_gnt       = '0;
    w_exit      = 1'b0;
    unique case (r_state)
      S_ARB_IDLE: begin
        w_gnt = w_pick;
        if ((|w_pick) && bus.lock_i[w_pidx]) begin
          if (MAX_BURST > 1) begin
            w_state_nxt = S_ARB_BUSY;
            w_owner_nxt = w_pidx;
            w_cnt_nxt   = CW'(1);
          end else begin
            w_excl_nxt = w_pick;
          end
        end
      end
      S_ARB_BUSY: begin
        if (bus.req_i[r_owner]) begin
          w_gnt     = port_oh(r_owner);
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_cnt_nxt >= CW'(MAX_BURST)) begin
            w_exit     = 1'b1;
            w_excl_nxt = port_oh(r_owner);
          end else if (!bus.lock_i[r_owner]) begin
            w_exit = 1'b1;
          end
        end else begin
          w_exit = 1'b1;
        end
        if (w_exit) begin
          w_state_nxt = S_ARB_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = S_ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_ARB_IDLE;
      r_owner <= PORT_VGA;
      r_cnt   <= '0;
      r_excl  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_excl  <= w_excl_nxt;
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (r_state == S_ARB_IDLE && (|w_pick))
      w_ptr_nxt = next_port(w_pidx);
    else if (w_exit)
      w_ptr_nxt = next_port(r_owner);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_ptr <= PORT_VGA;
    else         r_ptr <= w_ptr_nxt;
  end
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we_n  <= 1'b1;
    end else if (|w_gnt) begin
      r_addr  <= bus.addr_i[w_gidx];
      r_wdata <= bus.wdata_i[w_gidx];
      r_we_n  <= bus.we_n_i[w_gidx];
    end else begin
      r_we_n  <= 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i <= READ_LATENCY; i++)
        r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{valid: (|w_gnt) & bus.we_n_i[w_gidx],
                    port:  w_gidx};
      for (int i = 1; i <= READ_LATENCY; i++)
        r_tag[i] <= r_tag[i-1];
    end
  end

  assign bus.gnt_o           = Resetn ? w_gnt : '0;
  assign bus.SRAM_address    = r_addr;
  assign bus.SRAM_write_data = r_wdata;
  assign bus.SRAM_we_n       = r_we_n;
  assign bus.rdata_o         = bus.SRAM_read_data;
  assign bus.rvalid_o        = r_tag[READ_LATENCY].valid ?
                               port_oh(r_tag[READ_LATENCY].port) : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: cycle model plus literal spot checks.
module tb_sram_arbiter;

  localparam int RL   = 2;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  sram_arbiter_if ifc();

  sram_arbiter #(
    .MAX_BURST    (MAXB),
    .READ_LATENCY (RL)
  ) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  gnt_log [512];
  logic [2:0]  rv_log  [512];
  logic [17:0] addr_log[512];
  logic [15:0] wd_log  [512];
  logic        we_log  [512];

  int          m_owner = -1;
  int          m_burst = 0;
  int          m_excl  = -1;
`ifdef SRAM_ARB_RR_EN
  int          m_ptr   = 0;
`endif
  logic [17:0] e_addr  = '0;
  logic [15:0] e_wdata = '0;
  logic        e_we_n  = 1'b1;
  logic [2:0]  rv_at [int];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int model_pick();
    logic [2:0] req;
    logic [2:0] mask;
    int         p;
    req = ifc.req_i;
    if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
    mask = req;
    if (m_excl >= 0 && (req & ~(3'b001 << m_excl)) != 3'b000)
      mask[m_excl] = 1'b0;
    for (int i = 0; i < 3; i++) begin
`ifdef SRAM_ARB_RR_EN
      p = (m_ptr + i) % 3;
`else
      p = i;
`endif
      if (mask[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_release();
`ifdef SRAM_ARB_RR_EN
    m_ptr = (m_owner + 1) % 3;
`endif
    m_owner = -1;
    m_burst = 0;
  endtask

  task automatic model_update(input int g);
    int nx_excl;
    nx_excl = -1;
    if (m_owner >= 0) begin
      if (g < 0) model_release();
      else begin
        m_burst++;
        if (m_burst == MAXB) begin
          nx_excl = m_owner;
          model_release();
        end else if (!ifc.lock_i[m_owner]) begin
          model_release();
        end
      end
    end else if (g >= 0) begin
`ifdef SRAM_ARB_RR_EN
      m_ptr = (g + 1) % 3;
`endif
      if (ifc.lock_i[g]) begin
        m_owner = g;
        m_burst = 1;
      end
    end
    m_excl = nx_excl;
    if (g >= 0) begin
      e_addr  = ifc.addr_i[g];
      e_wdata = ifc.wdata_i[g];
      e_we_n  = ifc.we_n_i[g];
      if (ifc.we_n_i[g]) rv_at[cyc + 1 + RL] = 3'b001 << g;
    end else begin
      e_we_n = 1'b1;
    end
  endtask

  always @(negedge clk) begin : cmp
    int         g;
    logic [2:0] eg;
    logic [2:0] erv;
    gnt_log[cyc]  = ifc.gnt_o;
    rv_log[cyc]   = ifc.rvalid_o;
    addr_log[cyc] = ifc.SRAM_address;
    wd_log[cyc]   = ifc.SRAM_write_data;
    we_log[cyc]   = ifc.SRAM_we_n;
    if (!rst_n) begin
      m_owner = -1;
      m_burst = 0;
      m_excl  = -1;
`ifdef SRAM_ARB_RR_EN
      m_ptr   = 0;
`endif
      e_addr  = '0;
      e_wdata = '0;
      e_we_n  = 1'b1;
      rv_at.delete();
      chk("rst_gnt", 32'(ifc.gnt_o), 32'h0);
      chk("rst_we_n", 32'(ifc.SRAM_we_n), 32'h1);
      chk("rst_addr", 32'(ifc.SRAM_address), 32'h0);
      chk("rst_wdata", 32'(ifc.SRAM_write_data), 32'h0);
      chk("rst_rvalid", 32'(ifc.rvalid_o), 32'h0);
    end else begin
      g   = model_pick();
      eg  = (g >= 0) ? (3'b001 << g) : 3'b000;
      erv = rv_at.exists(cyc) ? rv_at[cyc] : 3'b000;
      chk("gnt", 32'(ifc.gnt_o), 32'(eg));
      chk("addr", 32'(ifc.SRAM_address), 32'(e_addr));
      chk("wdata", 32'(ifc.SRAM_write_data), 32'(e_wdata));
      chk("we_n", 32'(ifc.SRAM_we_n), 32'(e_we_n));
      chk("rvalid", 32'(ifc.rvalid_o), 32'(erv));
      chk("rdata", 32'(ifc.rdata_o), 32'(ifc.SRAM_read_data));
      model_update(g);
    end
  end

  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int c_wr, c_all, c_lk, c_ex, c_ul, c_rs, cnt1;
  logic [2:0] want;

  initial begin
    rst_n       = 1'b0;
    ifc.req_i   = 3'b001;
    ifc.lock_i  = '0;
    ifc.we_n_i  = 3'b111;
    ifc.addr_i  = '0;
    ifc.wdata_i = '0;
    ifc.SRAM_read_data = 16'h5A3C;
    go(3);
    rst_n     = 1'b1;
    ifc.req_i = '0;
    go(2);
    ifc.req_i[1]  = 1'b1;
    ifc.addr_i[1] = 18'h00100;
    go(1);
    ifc.req_i = '0;
    go(4);
    c_wr = cyc;
    ifc.req_i[2]   = 1'b1;
    ifc.we_n_i[2]  = 1'b0;
    ifc.addr_i[2]  = 18'h3FFFF;
    ifc.wdata_i[2] = 16'hBEEF;
    go(1);
    ifc.req_i  = '0;
    ifc.we_n_i = 3'b111;
    go(4);
    c_all = cyc;
    ifc.req_i  = 3'b111;
    ifc.addr_i = {18'h00C02, 18'h00B01, 18'h00A00};
    ifc.SRAM_read_data = 16'h1234;
    go(6);
    ifc.req_i = '0;
    go(4);
    c_lk = cyc;
    ifc.req_i[1]   = 1'b1;
    ifc.lock_i[1]  = 1'b1;
    ifc.we_n_i[1]  = 1'b0;
    ifc.wdata_i[1] = 16'h7E57;
    go(1);
    ifc.req_i[0] = 1'b1;
    go(16);
    ifc.req_i  = '0;
    ifc.lock_i = '0;
    ifc.we_n_i = 3'b111;
    go(4);
    c_ex = cyc;
    ifc.req_i[0]  = 1'b1;
    ifc.lock_i[0] = 1'b1;
    go(1);
    ifc.req_i[1] = 1'b1;
    go(16);
    ifc.req_i[1] = 1'b0;
    go(1);
    ifc.req_i  = '0;
    ifc.lock_i = '0;
    go(4);
    c_ul = cyc;
    ifc.req_i[0]  = 1'b1;
    ifc.lock_i[0] = 1'b1;
    go(1);
    ifc.req_i[1] = 1'b1;
    go(2);
    ifc.lock_i[0] = 1'b0;
    go(1);
    ifc.req_i[0] = 1'b0;
    go(1);
    ifc.req_i = '0;
    go(4);
    c_rs = cyc;
    ifc.req_i[2]  = 1'b1;
    ifc.addr_i[2] = 18'h12345;
    go(1);
    ifc.req_i = '0;
    rst_n     = 1'b0;
    go(1);
    rst_n = 1'b1;
    go(8);

    chk("lit_rd_gnt", 32'(gnt_log[5]), 32'h2);
    chk("lit_rd_addr", 32'(addr_log[6]), 32'h00100);
    chk("lit_rd_we_n", 32'(we_log[6]), 32'h1);
    chk("lit_rd_rv7", 32'(rv_log[7]), 32'h0);
    chk("lit_rd_rv8", 32'(rv_log[8]), 32'h2);

    chk("lit_wr_pre", 32'(we_log[c_wr]), 32'h1);
    chk("lit_wr_we", 32'(we_log[c_wr+1]), 32'h0);
    chk("lit_wr_addr", 32'(addr_log[c_wr+1]), 32'h3FFFF);
    chk("lit_wr_data", 32'(wd_log[c_wr+1]), 32'hBEEF);
    chk("lit_wr_post", 32'(we_log[c_wr+2]), 32'h1);
    chk("lit_wr_hold", 32'(addr_log[c_wr+2]), 32'h3FFFF);
    chk("lit_wr_norv", 32'(rv_log[c_wr+3]), 32'h0);

    for (int i = 0; i < 6; i++) begin
`ifdef SRAM_ARB_RR_EN
      want = 3'b001 << (i % 3);
`else
      want = 3'b001;
`endif
      chk("lit_all_gnt", 32'(gnt_log[c_all+i]), 32'(want));
    end

    cnt1 = 0;
    for (int i = 0; i < 16; i++)
      if (gnt_log[c_lk+i] == 3'b010) cnt1++;
    chk("lit_burst_cnt", 32'(cnt1), 32'd16);
    chk("lit_burst_next", 32'(gnt_log[c_lk+16]), 32'h1);

    chk("lit_excl_last", 32'(gnt_log[c_ex+15]), 32'h1);
    chk("lit_excl_skip", 32'(gnt_log[c_ex+16]), 32'h2);
    chk("lit_excl_back", 32'(gnt_log[c_ex+17]), 32'h1);

    for (int i = 0; i < 4; i++)
      chk("lit_unlock_gnt", 32'(gnt_log[c_ul+i]), 32'h1);
    chk("lit_unlock_next", 32'(gnt_log[c_ul+4]), 32'h2);

    chk("lit_rst_gnt", 32'(gnt_log[c_rs]), 32'h4);
    chk("lit_rst_addr", 32'(addr_log[c_rs+1]), 32'h0);
    chk("lit_rst_we_n", 32'(we_log[c_rs+1]), 32'h1);
    for (int i = 1; i <= 6; i++)
      chk("lit_rst_norv", 32'(rv_log[c_rs+i]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
